// File: rtl/stepper_pkg.sv
// Shared definitions for the two-axis STEP/DIR pulse generator.
//  - axis_state_t : per-axis state encoding (IDLE, SETUP, PULSE, WAIT)
//  - POS_W        : width of the signed step position
//  - CNT_W        : width of the per-axis tick counter and step period
//  - clamp_period : applies the minimum-period rule to a raw speed value
package stepper_pkg;

    typedef enum logic [1:0] {
        AX_IDLE  = 2'd0,
        AX_SETUP = 2'd1,
        AX_PULSE = 2'd2,
        AX_WAIT  = 2'd3
    } axis_state_t;

    localparam int POS_W = 32;
    localparam int CNT_W = 16;

    // A nonzero period shorter than one high phase plus one equal low phase
    // is stretched to 2*pulse_w ticks; zero passes through and means "stop".
    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] raw,
                                                      input int pulse_w);
        logic [CNT_W-1:0] min_p;
        min_p = CNT_W'(2 * pulse_w);
        if ((raw != '0) && (raw < min_p)) begin
            return min_p;
        end
        return raw;
    endfunction

endpackage

// File: rtl/stepper_axis.sv
// One stepper axis: state machine, tick counter, DIR pin and signed position.
// Everything advances only on cycles where the shared prescaler tick is high.
// Optional feature: STEP_SOFT_LIMIT_EN enables soft-limit suppression of steps
// that would take |pos| beyond POS_LIMIT.
// Ports:
//  clock, ctrl_reset  clock and synchronous active-high reset
//  tick               one-cycle strobe from the prescaler
//  dir_in             requested direction (1 = +)
//  speed_in           requested period in ticks (0 = stop), not yet clamped
//  step, dir          registered STEP / DIR pins
//  pos                signed step count
//  limit              soft limit active
//  active             axis not IDLE (combinational from the state register)
module stepper_axis
    import stepper_pkg::*;
#(
    parameter int PULSE_W   = 5,
    parameter int DIR_SETUP = 2,
    parameter int POS_LIMIT = 20000
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             tick,
    input  logic             dir_in,
    input  logic [CNT_W-1:0] speed_in,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic             limit,
    output logic             active
);

`ifdef STEP_SOFT_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    // Counters hold "ticks remaining minus one", so a phase ends on the tick
    // where the counter reads zero.
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] WAIT_SUB   = CNT_W'(PULSE_W + 1);

    axis_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             limit_q, limit_d;
    logic [POS_W-1:0] pos_q, pos_d;

    logic [CNT_W-1:0] period_eff;
    logic             resample;
    logic             start_pulse;
    logic             over_limit;

    assign period_eff = clamp_period(speed_in, PULSE_W);

    // Taking one more step in the current DIR direction would leave the band.
    assign over_limit = dir_q ? ($signed(pos_q) >= POS_LIMIT)
                              : ($signed(pos_q) <= -POS_LIMIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        dir_d       = dir_q;
        step_d      = step_q;
        limit_d     = limit_q;
        pos_d       = pos_q;
        resample    = 1'b0;
        start_pulse = 1'b0;

        if (tick) begin
            case (state_q)
                AX_IDLE: begin
                    resample = 1'b1;
                end
                AX_SETUP: begin
                    if (cnt_q == '0) begin
                        start_pulse = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                AX_PULSE: begin
                    if (cnt_q == '0) begin
                        step_d  = 1'b0;
                        state_d = AX_WAIT;
                        cnt_d   = period_q - WAIT_SUB;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                AX_WAIT: begin
                    if (cnt_q == '0) begin
                        resample = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = AX_IDLE;
                end
            endcase
        end

        // Speed and direction are only looked at here, so mid-period writes
        // wait for the next period boundary and DIR never moves under STEP.
        if (resample) begin
            if (period_eff == '0) begin
                state_d = AX_IDLE;
            end else begin
                period_d = period_eff;
                if (dir_in != dir_q) begin
                    dir_d   = dir_in;
                    state_d = AX_SETUP;
                    cnt_d   = SETUP_LAST;
                    limit_d = 1'b0;
                end else begin
                    start_pulse = 1'b1;
                end
            end
        end

        if (start_pulse) begin
            if (LIMIT_EN && over_limit) begin
                // Park in WAIT with an expired counter so every tick re-checks.
                state_d = AX_WAIT;
                cnt_d   = '0;
                limit_d = 1'b1;
            end else begin
                state_d = AX_PULSE;
                cnt_d   = PULSE_LAST;
                step_d  = 1'b1;
                limit_d = 1'b0;
                pos_d   = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q  <= AX_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            limit_q  <= 1'b0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            limit_q  <= limit_d;
            pos_q    <= pos_d;
        end
    end

    assign step   = step_q;
    assign dir    = dir_q;
    assign pos    = pos_q;
    assign limit  = limit_q;
    assign active = (state_q != AX_IDLE);

endmodule

// File: rtl/stepper_pulse_gen.sv
// Two-axis STEP/DIR pulse generator for the drawing robot. Turns the
// processor's direction/speed registers into driver pin waveforms and keeps a
// signed step position per axis.
// Optional feature: define STEP_SOFT_LIMIT_EN to enable the +/-POS_LIMIT soft
// limit; otherwise x_limit/y_limit stay 0 and positions wrap modulo 2^32.
// Ports:
//  clock, ctrl_reset           clock and synchronous active-high reset
//  step_x_dir, step_y_dir      bit0 = direction (1 = +), other bits ignored
//  step_x_speed, step_y_speed  step period in ticks, low SPEED_W bits, 0 = stop
//  x_step, y_step              registered STEP pins
//  x_dir, y_dir                registered DIR pins
//  x_pos, y_pos                signed step counts
//  x_limit, y_limit            soft limit active
//  busy                        either axis not IDLE
module stepper_pulse_gen
    import stepper_pkg::*;
#(
    parameter int CLK_DIV   = 50,
    parameter int PULSE_W   = 5,
    parameter int DIR_SETUP = 2,
    parameter int SPEED_W   = 16,
    parameter int POS_LIMIT = 20000
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] step_x_dir,
    input  logic [31:0] step_y_dir,
    input  logic [31:0] step_x_speed,
    input  logic [31:0] step_y_speed,
    output logic        x_step,
    output logic        y_step,
    output logic        x_dir,
    output logic        y_dir,
    output logic [31:0] x_pos,
    output logic [31:0] y_pos,
    output logic        x_limit,
    output logic        y_limit,
    output logic        busy
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick;

    assign tick = (presc_q == PRE_LAST);

    always_comb begin
        presc_d = tick ? '0 : (presc_q + PRE_W'(1));
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Index 0 = X, index 1 = Y.
    logic [1:0]       dir_req;
    logic [CNT_W-1:0] speed_req [2];
    logic [1:0]       step_w;
    logic [1:0]       dir_w;
    logic [1:0]       limit_w;
    logic [1:0]       active_w;
    logic [POS_W-1:0] pos_w [2];

    assign dir_req      = {step_y_dir[0], step_x_dir[0]};
    assign speed_req[0] = CNT_W'(step_x_speed[SPEED_W-1:0]);
    assign speed_req[1] = CNT_W'(step_y_speed[SPEED_W-1:0]);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            stepper_axis #(
                .PULSE_W   (PULSE_W),
                .DIR_SETUP (DIR_SETUP),
                .POS_LIMIT (POS_LIMIT)
            ) u_axis (
                .clock      (clock),
                .ctrl_reset (ctrl_reset),
                .tick       (tick),
                .dir_in     (dir_req[gi]),
                .speed_in   (speed_req[gi]),
                .step       (step_w[gi]),
                .dir        (dir_w[gi]),
                .pos        (pos_w[gi]),
                .limit      (limit_w[gi]),
                .active     (active_w[gi])
            );
        end
    endgenerate

    assign x_step  = step_w[0];
    assign y_step  = step_w[1];
    assign x_dir   = dir_w[0];
    assign y_dir   = dir_w[1];
    assign x_pos   = pos_w[0];
    assign y_pos   = pos_w[1];
    assign x_limit = limit_w[0];
    assign y_limit = limit_w[1];
    assign busy    = |active_w;

    // Register bits the hardware deliberately ignores.
    logic unused_bits;
    assign unused_bits = ^{step_x_dir[31:1], step_y_dir[31:1], step_x_speed, step_y_speed};

endmodule

// File: tb/tb_stepper_pulse_gen.sv
module tb_stepper_pulse_gen;

    localparam int CLK_DIV   = 2;
    localparam int PULSE_W   = 2;
    localparam int DIR_SETUP = 1;
    localparam int SPEED_W   = 16;
`ifdef STEP_SOFT_LIMIT_EN
    localparam int POS_LIMIT = 3;
`else
    localparam int POS_LIMIT = 20000;
`endif
    localparam int HIGH_CLK  = PULSE_W * CLK_DIV;
    localparam int SETUP_CLK = DIR_SETUP * CLK_DIV;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic [31:0] step_x_dir, step_y_dir, step_x_speed, step_y_speed;
    logic        x_step, y_step, x_dir, y_dir, x_limit, y_limit, busy;
    logic [31:0] x_pos, y_pos;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_pos [2];
    logic exp_dirpin [2];

    always #5 clock = ~clock;

    stepper_pulse_gen #(
        .CLK_DIV   (CLK_DIV),
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP),
        .SPEED_W   (SPEED_W),
        .POS_LIMIT (POS_LIMIT)
    ) dut (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .step_x_dir   (step_x_dir),
        .step_y_dir   (step_y_dir),
        .step_x_speed (step_x_speed),
        .step_y_speed (step_y_speed),
        .x_step       (x_step),
        .y_step       (y_step),
        .x_dir        (x_dir),
        .y_dir        (y_dir),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .x_limit      (x_limit),
        .y_limit      (y_limit),
        .busy         (busy)
    );

    function automatic logic get_step(input int ax);
        return (ax == 0) ? x_step : y_step;
    endfunction

    function automatic logic get_dir(input int ax);
        return (ax == 0) ? x_dir : y_dir;
    endfunction

    function automatic logic [31:0] get_pos(input int ax);
        return (ax == 0) ? x_pos : y_pos;
    endfunction

    // Reference period in ticks from the register value (minimum-period rule).
    function automatic int ref_period(input int spd);
        return (spd != 0 && spd < 2 * PULSE_W) ? 2 * PULSE_W : spd;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: got %0d, want %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Upper register bits carry random junk that the DUT must ignore.
    task automatic set_axis(input int ax, input logic d, input logic [15:0] spd);
        logic [31:0] dw;
        logic [31:0] sw;
        dw    = $urandom();
        dw[0] = d;
        sw    = {16'($urandom()), spd};
        if (ax == 0) begin
            step_x_dir   = dw;
            step_x_speed = sw;
        end else begin
            step_y_dir   = dw;
            step_y_speed = sw;
        end
    endtask

    task automatic wait_step(input int ax, input logic lvl, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (get_step(ax) !== lvl && n < bound);
    endtask

    task automatic wait_dir(input int ax, input logic lvl, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (get_dir(ax) !== lvl && n < bound);
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy !== 1'b0 && n < bound);
    endtask

    // From a rising edge: measure one full period and check width, period, position.
    task automatic one_period(input int ax, input int per_ticks, input string tag);
        int hi, lo;
        wait_step(ax, 1'b0, 200, hi);
        wait_step(ax, 1'b1, 200, lo);
        check({tag, "_width"}, hi, HIGH_CLK);
        check({tag, "_period"}, hi + lo, per_ticks * CLK_DIV);
        exp_pos[ax] += exp_dirpin[ax] ? 1 : -1;
        check({tag, "_pos"}, get_pos(ax), exp_pos[ax]);
    endtask

    initial begin
        int n, hi;
        ctrl_reset   = 1'b1;
        step_x_dir   = '0;
        step_y_dir   = '0;
        step_x_speed = '0;
        step_y_speed = '0;
        exp_pos      = '{0, 0};
        exp_dirpin   = '{1'b0, 1'b0};

        // 1. reset state
        repeat (10) @(negedge clock);
        check("rst_x_step", x_step, 0);
        check("rst_y_step", y_step, 0);
        check("rst_x_dir", x_dir, 0);
        check("rst_y_dir", y_dir, 0);
        check("rst_x_pos", x_pos, 0);
        check("rst_y_pos", y_pos, 0);
        check("rst_busy", busy, 0);
        check("rst_limits", {x_limit, y_limit}, 0);
        ctrl_reset = 1'b0;

        // 2. X at period 10, negative direction
        set_axis(0, 1'b0, 16'd10);
        wait_step(0, 1'b1, CLK_DIV + 2, n);
        check("t2_first_lat", (x_step === 1'b1 && n <= CLK_DIV), 1);
        exp_pos[0]--;
        check("t2_pos1", x_pos, exp_pos[0]);
        one_period(0, 10, "t2a");
        one_period(0, 10, "t2b");
        check("t2_x_pos_m3", x_pos, -3);
        check("t2_y_pos", y_pos, 0);
        check("t2_y_step", y_step, 0);
        check("t2_busy", busy, 1);
        $display("step2 x_pos=%0d", $signed(x_pos));

        // 3. reverse mid-period: DIR moves at the end of WAIT, STEP one setup later
        set_axis(0, 1'b1, 16'd10);
        wait_dir(0, 1'b1, 60, n);
        check("t3_dir_at_wait_end", n, 10 * CLK_DIV);
        check("t3_step_low_at_dir", x_step, 0);
        wait_step(0, 1'b1, 20, n);
        check("t3_setup_clocks", n, SETUP_CLK);
        exp_dirpin[0] = 1'b1;
        exp_pos[0]++;
        check("t3_pos", x_pos, exp_pos[0]);
        one_period(0, 10, "t3a");
        $display("step3 x_pos=%0d x_dir=%0d", $signed(x_pos), x_dir);

        // 4. speed 1 clamps to 2*PULSE_W ticks, then stop mid-pulse
        set_axis(0, 1'b1, 16'd1);
        one_period(0, 10, "t4_old");
        one_period(0, 2 * PULSE_W, "t4_clamp");
        set_axis(0, 1'b1, 16'd0);
        wait_step(0, 1'b0, 40, hi);
        check("t4_last_width", hi, HIGH_CLK);
        wait_idle(40, n);
        check("t4_idle_after", n, (2 * PULSE_W - PULSE_W) * CLK_DIV);
        wait_step(0, 1'b1, 20, n);
        check("t4_no_more_steps", {x_step, busy}, 0);
        $display("step4 x_pos=%0d busy=%0d", $signed(x_pos), busy);

        // 5. reset in the middle of a pulse
        set_axis(0, 1'b1, 16'd10);
        wait_step(0, 1'b1, CLK_DIV + 2, n);
        check("t5_lat", (x_step === 1'b1 && n <= CLK_DIV), 1);
        exp_pos[0]++;
        check("t5_pos_before", x_pos, exp_pos[0]);
        ctrl_reset = 1'b1;
        @(negedge clock);
        check("t5_step_cleared", x_step, 0);
        check("t5_pos_cleared", x_pos, 0);
        check("t5_dir_cleared", x_dir, 0);
        check("t5_busy_cleared", busy, 0);
        set_axis(0, 1'b0, 16'd0);
        ctrl_reset = 1'b0;
        exp_pos[0] = 0;
        exp_dirpin[0] = 1'b0;
        $display("step5 reset mid-pulse");

`ifdef STEP_SOFT_LIMIT_EN
        // 6. soft limit at +/-3
        set_axis(0, 1'b1, 16'd4);
        wait_step(0, 1'b1, CLK_DIV + SETUP_CLK + 2, n);
        check("t6_lat", (x_step === 1'b1 && n <= CLK_DIV + SETUP_CLK), 1);
        exp_dirpin[0] = 1'b1;
        exp_pos[0] = 1;
        check("t6_pos1", x_pos, exp_pos[0]);
        one_period(0, 4, "t6a");
        one_period(0, 4, "t6b");
        wait_step(0, 1'b0, 20, n);
        wait_step(0, 1'b1, 30, n);
        check("t6_suppressed", x_step, 0);
        check("t6_limit_set", x_limit, 1);
        check("t6_pos_held", x_pos, POS_LIMIT);
        set_axis(0, 1'b0, 16'd4);
        wait_step(0, 1'b1, 20, n);
        check("t6_resumed", x_step, 1);
        check("t6_limit_clear", x_limit, 0);
        check("t6_dir_back", x_dir, 0);
        check("t6_pos_dec", x_pos, POS_LIMIT - 1);
        $display("step6 x_pos=%0d x_limit=%0d", $signed(x_pos), x_limit);
`else
        // Random segments on either axis, each started from IDLE.
        for (int it = 0; it < 10; it++) begin
            int ax, spd, pe, bound, other;
            logic d;
            ax    = int'($urandom_range(0, 1));
            other = 1 - ax;
            spd   = int'($urandom_range(1, 12));
            d     = 1'($urandom_range(0, 1));
            pe    = ref_period(spd);
            repeat ($urandom_range(0, 3)) @(negedge clock);
            bound = CLK_DIV + ((d != exp_dirpin[ax]) ? SETUP_CLK : 0);
            set_axis(ax, d, 16'(spd));
            wait_step(ax, 1'b1, bound + 2, n);
            check("rnd_first_lat", (get_step(ax) === 1'b1 && n <= bound), 1);
            exp_dirpin[ax] = d;
            check("rnd_dir_pin", get_dir(ax), exp_dirpin[ax]);
            exp_pos[ax] += d ? 1 : -1;
            check("rnd_pos_first", get_pos(ax), exp_pos[ax]);
            for (int k = 0; k < 3; k++) begin
                one_period(ax, pe, "rnd");
            end
            set_axis(ax, d, 16'd0);
            wait_step(ax, 1'b0, 200, hi);
            check("rnd_stop_width", hi, HIGH_CLK);
            wait_idle(200, n);
            check("rnd_stop_idle", n, (pe - PULSE_W) * CLK_DIV);
            check("rnd_other_pos", get_pos(other), exp_pos[other]);
            $display("seg %0d axis=%0d speed=%0d dir=%0d pos=%0d", it, ax, spd, d,
                     $signed(get_pos(ax)));
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
